// File: rtl/md_issue_if.sv
// md_issue_if: EX-stage side and HI/LO-unit side of the mul/div issue block.
// master drives the EX instruction; slave is the issue controller.
interface md_issue_if;
  logic        ex_valid;
  logic [2:0]  ex_mdop;
  logic        ex_sign;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_rd_hilo;
  logic        flush;
  logic [2:0]  md_F;
  logic        md_sign;
  logic [31:0] md_A;
  logic [31:0] md_B;
  logic        stall;
  logic        busy;
  logic        div0_exc;

  modport master (
    output ex_valid,
    output ex_mdop,
    output ex_sign,
    output ex_a,
    output ex_b,
    output ex_rd_hilo,
    output flush,
    input  md_F,
    input  md_sign,
    input  md_A,
    input  md_B,
    input  stall,
    input  busy,
    input  div0_exc
  );

  modport slave (
    input  ex_valid,
    input  ex_mdop,
    input  ex_sign,
    input  ex_a,
    input  ex_b,
    input  ex_rd_hilo,
    input  flush,
    output md_F,
    output md_sign,
    output md_A,
    output md_B,
    output stall,
    output busy,
    output div0_exc
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues a one-cycle HI/LO function pulse, then holds
// an interlock window until the result is architecturally visible.
module md_issue_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input logic       clk,
  input logic       rst_n,
  md_issue_if.slave bus
);

  localparam int MAX_LAT =
    (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  localparam logic [CW-1:0] MUL_LD =
    CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DIV_LD =
    CW'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  f_q, f_d;
  logic        sign_q, sign_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        busy_q, busy_d;
  logic        div0_q, div0_d;

  logic [2:0]  op;
  logic        idle;
  logic        accept;
  logic        div0;
  logic        issue;
  logic        short_op;

  always_comb begin
    op = bus.ex_mdop;
    if (bus.ex_mdop > OP_DIV) op = OP_NONE;
  end

  assign idle   = (state_q == S_IDLE);
  assign accept = bus.ex_valid & ~bus.flush &
                  (op != OP_NONE) & idle;
  assign div0   = accept & (op == OP_DIV) &
                  (bus.ex_b == '0);
  assign issue  = accept & ~div0;

  // f_q still holds the issued op while in ISSUE
  always_comb begin
    short_op = 1'b1;
    unique case (1'b1)
      (f_q == OP_MUL): short_op = (MUL_LAT == 1);
      (f_q == OP_DIV): short_op = (DIV_LAT == 1);
      default:         short_op = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = OP_NONE;
    sign_d  = sign_q;
    a_d     = a_q;
    b_d     = b_q;
    div0_d  = div0;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_ISSUE;
          f_d     = op;
          sign_d  = bus.ex_sign;
          a_d     = bus.ex_a;
          b_d     = bus.ex_b;
        end
      end
      S_ISSUE: begin
        if (short_op) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = (f_q == OP_MUL) ? MUL_LD : DIV_LD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f_q     <= OP_NONE;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.stall = bus.ex_valid & ~bus.flush &
                     (bus.ex_rd_hilo | (op != OP_NONE)) &
                     ~idle;
  assign bus.md_F     = f_q;
  assign bus.md_sign  = sign_q;
  assign bus.md_A     = a_q;
  assign bus.md_B     = b_q;
  assign bus.busy     = busy_q;
  assign bus.div0_exc = div0_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed scenarios plus random traffic checked
// against a remaining-busy-cycles model of the issue controller.
module tb_md_issue_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_issue_if bus ();

  md_issue_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errs = 0;
  int checks = 0;

  int          rem;
  logic [2:0]  m_f;
  logic        m_sign;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_div0;

  function automatic logic [2:0] norm(logic [2:0] o);
    return (o > 3'd4) ? 3'd0 : o;
  endfunction

  function automatic int lat(logic [2:0] o);
    if (o == 3'd3) return MUL_LAT;
    if (o == 3'd4) return DIV_LAT;
    return 1;
  endfunction

  function automatic logic m_stall();
    return bus.ex_valid & ~bus.flush & (rem > 0) &
           (bus.ex_rd_hilo | (norm(bus.ex_mdop) != 3'd0));
  endfunction

  task automatic model_reset();
    rem = 0;
    m_f = 3'd0;
    m_sign = 1'b0;
    m_a = '0;
    m_b = '0;
    m_div0 = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic rd,
                       input logic fl);
    bus.ex_valid = v;
    bus.ex_mdop = op;
    bus.ex_sign = s;
    bus.ex_a = a;
    bus.ex_b = b;
    bus.ex_rd_hilo = rd;
    bus.flush = fl;
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // One clock: the instruction in EX is taken iff nothing is in flight.
  task automatic tick();
    logic [2:0]  op;
    logic        acc;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    op  = norm(bus.ex_mdop);
    acc = bus.ex_valid & ~bus.flush & (op != 3'd0) & (rem == 0);
    s = bus.ex_sign;
    a = bus.ex_a;
    b = bus.ex_b;
    @(posedge clk);
    #1;
    m_f = 3'd0;
    m_div0 = 1'b0;
    if (rem > 0) rem--;
    if (acc) begin
      if (op == 3'd4 && b == 32'd0) begin
        m_div0 = 1'b1;
      end else begin
        m_f = op;
        m_sign = s;
        m_a = a;
        m_b = b;
        rem = lat(op);
      end
    end
    if (!rst_n) model_reset();
  endtask

  task automatic settle();
    idle_in();
    for (int i = 0; i < 64 && rem > 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 3'd3, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errs++;
      $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    checks++;
    if ({bus.md_F, bus.md_sign, bus.md_A, bus.md_B,
         bus.busy, bus.div0_exc} !== '0) begin
      errs++;
      $display("FAIL reset_outs: F=%0d busy=%b want all 0",
               bus.md_F, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    idle_in();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 3'd3, 1'b0, 32'd5, 32'd6, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    drive(1'b1, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.md_F, bus.md_sign, bus.md_A, bus.md_B,
         bus.busy, bus.div0_exc, bus.stall} !== '0) begin
      errs++;
      $display("FAIL rst_mid_outs: F=%0d A=%h busy=%b st=%b want 0",
               bus.md_F, bus.md_A, bus.busy, bus.stall);
    end
    tick();
    rst_n = 1'b1;
    idle_in();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.md_F !== 3'd0 || bus.busy !== 1'b0) begin
        errs++;
        $display("FAIL rst_mid_after: F=%0d busy=%b want 0 0",
                 bus.md_F, bus.busy);
      end
    end
  endtask

  task automatic test_mul();
    int n;
    drive(1'b1, 3'd3, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errs++;
      $display("FAIL mul_acc_stall: got %b want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.md_F !== 3'd3 || bus.md_sign !== 1'b1 ||
        bus.md_A !== 32'hFFFF_FFFE || bus.md_B !== 32'd3) begin
      errs++;
      $display("FAIL mul_issue: F=%0d s=%b A=%h B=%h want 3 1 fffffffe 3",
               bus.md_F, bus.md_sign, bus.md_A, bus.md_B);
    end
    drive(1'b1, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.stall) break;
      n++;
      tick();
      checks++;
      if (bus.md_F !== 3'd0) begin
        errs++;
        $display("FAIL mul_pulse: F=%0d in wait want 0", bus.md_F);
      end
    end
    checks++;
    if (n != MUL_LAT) begin
      errs++;
      $display("FAIL mul_stall_len: got %0d want %0d", n, MUL_LAT);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL mul_busy_end: got %b want 0", bus.busy);
    end
    settle();
  endtask

  task automatic test_div0();
    drive(1'b1, 3'd4, 1'b1, 32'd9, 32'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.md_F !== 3'd0 || bus.div0_exc !== 1'b1 ||
        bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL div0: F=%0d exc=%b busy=%b want 0 1 0",
               bus.md_F, bus.div0_exc, bus.busy);
    end
    drive(1'b1, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errs++;
      $display("FAIL div0_mfhi_stall: got %b want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.div0_exc !== 1'b0) begin
      errs++;
      $display("FAIL div0_pulse: exc=%b want 0", bus.div0_exc);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int n;
    drive(1'b1, 3'd2, 1'b0, 32'hA5A5_5A5A, 32'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.md_F !== 3'd2 || bus.md_A !== 32'hA5A5_5A5A) begin
      errs++;
      $display("FAIL b2b_mtlo: F=%0d A=%h want 2 a5a55a5a",
               bus.md_F, bus.md_A);
    end
    drive(1'b1, 3'd4, 1'b0, 32'd7, 32'd2, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin
      errs++;
      $display("FAIL b2b_stall: got %b want 1", bus.stall);
    end
    tick();
    checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_free: stall=%b busy=%b want 0 0",
               bus.stall, bus.busy);
    end
    tick();
    checks++;
    if (bus.md_F !== 3'd4 || bus.md_A !== 32'd7 ||
        bus.md_B !== 32'd2) begin
      errs++;
      $display("FAIL b2b_div: F=%0d A=%0d B=%0d want 4 7 2",
               bus.md_F, bus.md_A, bus.md_B);
    end
    idle_in();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!bus.busy) break;
      n++;
      tick();
    end
    checks++;
    if (n != DIV_LAT) begin
      errs++;
      $display("FAIL b2b_div_busy: got %0d want %0d", n, DIV_LAT);
    end
    settle();
  endtask

  task automatic test_flush();
    int n;
    drive(1'b1, 3'd3, 1'b0, 32'd1, 32'd2, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.md_F !== 3'd0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL flush_acc: F=%0d busy=%b want 0 0",
               bus.md_F, bus.busy);
    end
    drive(1'b1, 3'd3, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b0, 32'd1, 32'd2, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      n++;
      tick();
    end
    checks++;
    if (n != MUL_LAT) begin
      errs++;
      $display("FAIL flush_wait_busy: got %0d want %0d", n, MUL_LAT);
    end
    settle();
  endtask

  task automatic test_random();
    logic        v;
    logic [2:0]  op;
    logic        rd;
    logic        fl;
    logic [31:0] b;
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      rd = (norm(op) == 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
      fl = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      drive(v, op, 1'($urandom_range(0, 1)), $urandom, b, rd, fl);
      checks++;
      if (bus.stall !== m_stall()) begin
        errs++;
        $display("FAIL rnd_stall @%0d: got %b want %b",
                 i, bus.stall, m_stall());
      end
      tick();
      checks++;
      if ({bus.md_F, bus.busy, bus.div0_exc} !==
          {m_f, (rem > 0), m_div0}) begin
        errs++;
        $display("FAIL rnd_out @%0d: F/busy/exc=%0d%b%b want %0d%b%b",
                 i, bus.md_F, bus.busy, bus.div0_exc,
                 m_f, (rem > 0), m_div0);
      end
      if (m_f != 3'd0) begin
        checks++;
        if ({bus.md_sign, bus.md_A, bus.md_B} !==
            {m_sign, m_a, m_b}) begin
          errs++;
          $display("FAIL rnd_opnd @%0d: s=%b A=%h B=%h want %b %h %h",
                   i, bus.md_sign, bus.md_A, bus.md_B,
                   m_sign, m_a, m_b);
        end
      end
    end
    settle();
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_reset_mid_wait();
    test_mul();
    test_div0();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and interlock controller placed directly upstream of the HI/LO multiply/divide unit in the EX stage. It accepts the multiply/divide/move-to-HI/LO operation from the EX pipeline register and drives the unit's function code, sign flag and operands as a registered one-cycle pulse. It then enforces a per-operation busy window, stalling later HI/LO reads and further MD operations until the result is architecturally visible. It also suppresses divide-by-zero and reports it as an exception pulse.

## Interface
- MUL_LAT, default 4: busy cycles for a multiply, ≥1.
- DIV_LAT, default 33: busy cycles for a divide, ≥1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_mdop  in  3  0 none, 1 mthi, 2 mtlo, 3 mul, 4 div; values 5–7 are treated as 0.
- ex_sign  in  1  signed variant of mul/div.
- ex_a, ex_b  in  32 each  operands; mthi/mtlo use ex_a only.
- ex_rd_hilo  in  1  EX instruction reads HI or LO (mfhi/mflo).
- flush  in  1  kill the EX instruction this cycle.
- md_F  out  3  function code to the HI/LO unit; nonzero for exactly one cycle per issue.
- md_sign  out  1  sign flag to the HI/LO unit.
- md_A, md_B  out  32 each  operands to the HI/LO unit.
- stall  out  1  combinational; freezes the IF/ID/EX stages.
- busy  out  1  registered; high while the state is not IDLE.
- div0_exc  out  1  registered one-cycle pulse.

## Operation
- States:
  - IDLE: no operation in flight.
  - ISSUE: md_F is driven for this one cycle.
  - WAIT: a down-counter runs to completion.
- Accept condition: ex_valid & op≠0 & ~flush & state==IDLE.
- On accept, the next edge registers md_F←op, md_sign←ex_sign, md_A←ex_a, md_B←ex_b and moves the state to ISSUE.
- Div-by-zero exception:
  - Applies when op==4 and ex_b==0 on an accept.
  - md_F stays 0 and the state stays IDLE.
  - div0_exc=1 for the next cycle.
  - The instruction counts as consumed.
- ISSUE → IDLE after one cycle:
  - for mthi/mtlo;
  - for mul when MUL_LAT==1;
  - for div when DIV_LAT==1.
- Otherwise ISSUE → WAIT, with the counter loaded to (LAT−2). WAIT → IDLE on the edge where the counter reads 0; otherwise the counter decrements.
- stall = ex_valid & ~flush & (ex_rd_hilo | op≠0) & state≠IDLE.
- stall is low in the accepting cycle itself.
- flush in the accepting cycle blocks the accept; no state change and no div0_exc.
- flush during ISSUE or WAIT does not cancel the in-flight operation, because the HI/LO update is already committed.
- md_F is 0 in every cycle except ISSUE. md_A, md_B and md_sign hold their last values outside ISSUE.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).

## Timing
- Reset (asynchronous assert) forces: state IDLE, counter 0, md_F=0, md_sign=0, md_A=0, md_B=0, busy=0, div0_exc=0. stall is then 0 for any input.
- Reset asserted mid-operation abandons the operation immediately. No md_F pulse may follow reset release.
- Accept at edge E0 puts md_F valid in cycle E0–E1. The HI/LO unit commits at E1.
- busy length (from E0): mthi/mtlo 1 cycle, mul MUL_LAT cycles, div DIV_LAT cycles.
- A dependent mfhi/mflo, or a second MD op, presented immediately after the accept stalls for exactly that busy count. It proceeds (or is accepted) in the first cycle with state IDLE.
- Back-to-back MD ops therefore issue at most once every busy-count+1 cycles.
- An MD op and a concurrent HI/LO read cannot occur in the same EX instruction.

## Test plan
- Reset mid-WAIT: mul accepted, rst_n low 2 cycles later → all outputs 0 asynchronously; after release, busy=0 and no md_F pulse.
- mul with MUL_LAT=4:
  - Stimulus: ex_mdop=3, ex_sign=1, ex_a=0xFFFFFFFE, ex_b=3, then mflo held in EX.
  - Required: md_F=3 for one cycle with md_A=0xFFFFFFFE, md_B=3.
  - Required: stall high exactly 4 cycles; mflo proceeds in cycle 5 after the accept.
- Divide by zero: ex_mdop=4, ex_b=0 → md_F stays 0, div0_exc pulses 1 cycle, busy stays 0, a following mfhi is not stalled.
- Back-to-back mtlo then div(7,2) with DIV_LAT=33:
  - md_F=2 then 1 stall cycle.
  - md_F=4 with md_A=7, md_B=2.
  - busy for 33 cycles.
- Flush:
  - flush together with mul → no md_F pulse, busy 0.
  - flush raised during WAIT → busy still runs the full MUL_LAT.
